// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a bounded memory wait.
// Define ILLEGAL_TRAP_EN to park undefined opcodes in TRAP; otherwise they retire as a NOP from DECODE.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [1:0]          pc_src,
  output logic [3:0]          state,
  output logic                instr_done,
  output logic                mem_timeout
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                expired;

  // Counter clears by default, so every state entry and every mem_ready start from zero.
  assign expired = (cnt_q == WAIT_W'(MAX_WAIT)) && !mem_ready;
  assign state   = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUop         = '0;
    pc_src        = 2'b00;
    instr_done    = 1'b0;
    mem_timeout   = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (OpCode == OP_RTYPE)                     state_d = EXEC;
        else if (OpCode == OP_LW || OpCode == OP_SW) state_d = MEMADDR;
        else if (OpCode == OP_BEQ)                  state_d = BRANCH;
        else if (OpCode == OP_J)                    state_d = JUMP;
        else if (OpCode == OP_ADDI)                 state_d = ADDIEX;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          instr_done = 1'b1;
          state_d    = FETCH;
`endif
        end
      end
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (OpCode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        i_or_d = 1'b1;
        // The write request is withdrawn in the expiring cycle so nothing commits on timeout.
        mem_write = !expired;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        ALUop     = ALUOP_W'(2'b10);
        state_d   = RWB;
      end
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = ALUOP_W'(2'b01);
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level reference model expanded into per-cycle expectations.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control_unit;
  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 2;
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [OPCODE_W-1:0] OpCode;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, mem_timeout;
  logic [1:0] alu_src_b, pc_src;
  logic [ALUOP_W-1:0] ALUop;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUop(ALUop), .pc_src(pc_src),
    .state(state), .instr_done(instr_done), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic done, tmo;
    logic [3:0] st;
  } ovec_t;
  typedef struct { bit rdy; logic [5:0] opc; ovec_t exp; } cyc_t;
  typedef struct { int lat; bit tmo; } ins_t;

  ovec_t act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, ALUop, pc_src, instr_done,
                mem_timeout, state};

  cyc_t  stim_q[$];
  ovec_t exp_q[$];
  ins_t  iq[$];
  int n_chk = 0;
  int n_err = 0;
  bit drv_done = 0;

  task automatic check(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic ovec_t blank(logic [3:0] st);
    ovec_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic bit coin();
    return bit'($urandom % 2);
  endfunction

  task automatic push(ovec_t o, bit rdy, logic [5:0] opc);
    stim_q.push_back('{rdy, opc, o});
  endtask

  // One instruction: wf/wm are memory wait cycles before ready; any value above MAX_WAIT means ready never comes.
  task automatic gen_instr(logic [5:0] opc, int wf, int wm);
    ovec_t o;
    int n;
    bit to, is_lw, legal;
    n = 0;
    to = 0;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      o = blank(4'd0); o.mrd = 1; o.asb = 2'b01;
      if (i == wf) begin
        o.irw = 1; o.pcw = 1; push(o, 1, opc); n++;
        break;
      end
      if (i == MAX_WAIT) begin o.tmo = 1; to = 1; end
      push(o, 0, opc); n++;
    end
    if (to) begin iq.push_back('{n, 1'b1}); return; end

    legal = (opc == 6'd0 || opc == 6'd35 || opc == 6'd43 || opc == 6'd4 || opc == 6'd2 || opc == 6'd8);
    o = blank(4'd1); o.asb = 2'b11;
    if (!legal) o.done = 1;
    push(o, coin(), opc); n++;
    if (!legal) begin iq.push_back('{n, 1'b0}); return; end

    case (opc)
      6'd0: begin
        o = blank(4'd6); o.asa = 1; o.aop = 2'b10; push(o, coin(), opc); n++;
        o = blank(4'd7); o.rw = 1; o.rdst = 1; o.done = 1; push(o, coin(), opc); n++;
      end
      6'd8: begin
        o = blank(4'd10); o.asa = 1; o.asb = 2'b10; push(o, coin(), opc); n++;
        o = blank(4'd11); o.rw = 1; o.done = 1; push(o, coin(), opc); n++;
      end
      6'd4: begin
        o = blank(4'd8); o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.psrc = 2'b01; o.done = 1;
        push(o, coin(), opc); n++;
      end
      6'd2: begin
        o = blank(4'd9); o.pcw = 1; o.psrc = 2'b10; o.done = 1; push(o, coin(), opc); n++;
      end
      default: begin
        is_lw = (opc == 6'd35);
        o = blank(4'd2); o.asa = 1; o.asb = 2'b10; push(o, coin(), opc); n++;
        for (int i = 0; i <= MAX_WAIT; i++) begin
          o = blank(is_lw ? 4'd3 : 4'd5); o.iord = 1;
          if (is_lw) o.mrd = 1; else o.mwr = 1;
          if (i == wm) begin
            if (!is_lw) o.done = 1;
            push(o, 1, opc); n++;
            break;
          end
          if (i == MAX_WAIT) begin o.tmo = 1; o.mwr = 0; to = 1; end
          push(o, 0, opc); n++;
        end
        if (to) begin iq.push_back('{n, 1'b1}); return; end
        if (is_lw) begin
          o = blank(4'd4); o.rw = 1; o.m2r = 1; o.done = 1; push(o, coin(), opc); n++;
        end
      end
    endcase
    iq.push_back('{n, 1'b0});
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom % 7)
      0: return 6'd0;
      1: return 6'd35;
      2: return 6'd43;
      3: return 6'd4;
      4: return 6'd2;
      5: return 6'd8;
`ifdef ILLEGAL_TRAP_EN
      default: return 6'd0;
`else
      default: return 6'h30 | 6'($urandom % 16);
`endif
    endcase
  endfunction

  function automatic int pick_wait();
    if ($urandom % 12 == 0) return MAX_WAIT + 1;
    return int'($urandom % 4);
  endfunction

  initial begin
    ovec_t ev;
    bit found;
    rst = 1; mem_ready = 0; OpCode = '0;

    gen_instr(6'd0, 0, 0);
    gen_instr(6'd35, 0, 3);
    gen_instr(6'd43, 0, 0);
    gen_instr(6'd4, 0, 0);
    gen_instr(6'd2, 0, 0);
    gen_instr(6'd0, MAX_WAIT + 1, 0);
`ifndef ILLEGAL_TRAP_EN
    gen_instr(6'h3f, 0, 0);
`endif
    gen_instr(6'd35, 2, MAX_WAIT + 1);
    gen_instr(6'd43, 0, MAX_WAIT + 1);
    gen_instr(6'd0, MAX_WAIT, 0);
    gen_instr(6'd43, 1, MAX_WAIT);
    for (int k = 0; k < 40; k++) gen_instr(pick_op(), pick_wait(), pick_wait());

    repeat (2) @(posedge clk);
    @(negedge clk);
    ev = blank(4'd0); ev.mrd = 1; ev.asb = 2'b01;
    check("reset_outputs", int'(act), int'(ev));

    @(posedge clk); #1;
    rst = 0; mem_ready = 1; OpCode = 6'd0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (state == 4'd6) found = 1;
    end
    check("reach_exec", int'(found), 1);
    rst = 1;
    @(posedge clk); #1;
    check("rst_abort_state", int'(state), 0);
    check("rst_abort_reg_write", int'(reg_write), 0);
    @(posedge clk); #1;
    rst = 0;

    fork
      begin
        cyc_t c;
        while (stim_q.size() > 0) begin
          c = stim_q.pop_front();
          mem_ready = c.rdy;
          OpCode = c.opc;
          exp_q.push_back(c.exp);
          @(posedge clk); #1;
        end
        drv_done = 1;
      end
      begin
        ovec_t e;
        ins_t  r;
        int lat;
        lat = 0;
        while (1) begin
          @(negedge clk);
          if (drv_done) break;
          if (exp_q.size() == 0) begin
            check("exp_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("cycle_outputs", int'(act), int'(e));
          end
          lat++;
          if (instr_done || mem_timeout) begin
            if (iq.size() == 0) begin
              check("unexpected_event", 1, 0);
            end else begin
              r = iq.pop_front();
              check("latency", lat, r.lat);
              check("event_kind", int'(mem_timeout), int'(r.tmo));
            end
            lat = 0;
          end
        end
      end
    join
    check("instr_left", iq.size(), 0);
    check("cycles_left", exp_q.size(), 0);

    rst = 1; mem_ready = 1; OpCode = 6'h3f;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("illegal_fetch_state", int'(state), 0);
    @(negedge clk);
    check("illegal_decode_state", int'(state), 1);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_decode_done", int'(instr_done), 0);
    repeat (4) begin
      @(negedge clk);
      check("trap_hold", int'(act), int'(blank(4'd12)));
    end
    rst = 1;
    @(posedge clk); #1;
    check("trap_reset", int'(state), 0);
`else
    check("illegal_decode_done", int'(instr_done), 1);
    @(negedge clk);
    check("illegal_return_fetch", int'(state), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
FSM-based control unit for the multi-cycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states, asserting datapath enables per state. It stalls memory states on a ready handshake with a bounded wait counter. It also supports addi and j in addition to R-type, lw, sw and beq.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 2, ALU-op bus width to the ALU control decoder
WAIT_W, 4, width of the memory wait counter
MAX_WAIT, 15, memory wait cycles allowed before timeout (1..2^WAIT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
OpCode  in  OPCODE_W  instruction opcode, taken from the IR output
mem_ready  in  1  memory completed the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR
reg_dst  out  1  destination select: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0=PC, 1=rs
alu_src_b  out  2  ALU B select: 00=rt, 01=4, 10=signext, 11=signext<<2
ALUop  out  ALUOP_W  00=add, 01=sub, 10=funct
pc_src  out  2  PC source select: 00=ALU, 01=ALUOut, 10=jump target
state  out  4  current state encoding, for debug
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
mem_timeout  out  1  one-cycle pulse when a memory wait expires

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Reset: on rst, next clock edge goes to state=FETCH and wait counter=0. All outputs follow from that state, i.e. FETCH defaults with ir_write/pc_write=0 until mem_ready. rst mid-instruction aborts the instruction; no partial writeback occurs after the reset edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=00, pc_src=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; advance to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ALUop=00. Next state by OpCode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - other -> illegal (see Optional Feature)
- MEMADDR: alu_src_a=1, alu_src_b=10, ALUop=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Advance to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, ALUop=10; -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=01, pc_write_cond=1, pc_src=01, instr_done=1; -> FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1; -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ALUop=00; -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; -> FETCH.
- Output defaults: any output not listed for a state is 0.
- Memory wait counter (FETCH/MEMRD/MEMWR):
  - Cleared on entry to the state and on mem_ready.
  - Increments each cycle mem_ready=0.
  - When count==MAX_WAIT and mem_ready=0: mem_timeout=1 for that cycle, no write enables asserted, -> FETCH, counter cleared.
  - mem_ready=1 in the same cycle as count==MAX_WAIT is a success, not a timeout.
  - A timeout in FETCH re-fetches the same PC, since pc_write is not asserted.
- Latency with mem_ready always high:
  - R-type/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/j: 3 cycles

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an undefined OpCode in DECODE -> TRAP. TRAP asserts no enables and instr_done=0, and holds until rst.
- Undefined: an undefined OpCode is a NOP. DECODE -> FETCH with instr_done=1 in the DECODE cycle.

Test Plan:
- rst=1 for 2 cycles, then mem_ready=1, OpCode=000000 -> state 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_done pulses on cycle 4.
- lw (100011), mem_ready low 3 cycles in MEMRD -> stays in state 3 for 4 cycles; MEMWB has reg_write=1, mem_to_reg=1; total latency 8 cycles.
- sw (101011) with mem_ready=1 -> mem_write=1 exactly one cycle in state 5; reg_write never asserted.
- beq (000100) then j (000010) -> state 8 with pc_write_cond=1, pc_src=01, ALUop=01; then state 9 with pc_write=1, pc_src=10.
- mem_ready held 0 in FETCH, MAX_WAIT=15 -> mem_timeout pulses on the 16th cycle; ir_write and pc_write stay 0; FSM remains/returns to FETCH.
- OpCode=111111 -> with ILLEGAL_TRAP_EN, state=12 held until rst; without it, DECODE emits instr_done=1 and returns to FETCH. Separately, rst asserted in state 6 -> next cycle state=0, reg_write=0.
